// File: rtl/pack_ser_pkg.sv
// Shared encodings and widths for the pack_serializer block.
// PACK_SER_PARITY_EN adds the PARITY state to the FSM encoding.
package pack_ser_pkg;

  localparam int CODE_W = 8;
  localparam int OPND_W = 3;

  localparam logic MODE_XY8  = 1'b0;
  localparam logic MODE_YX16 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef PACK_SER_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/pack_code.sv
// Combinational operand packer: mode 0 gives 8*x+y, mode 1 gives x+16*y.
// Both forms are pure bit placement, so no carries and no overflow.
module pack_code
  import pack_ser_pkg::*;
(
  input  logic              mode,
  input  logic [OPND_W-1:0] x,
  input  logic [OPND_W-1:0] y,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = '0;
    if (mode == MODE_XY8) begin
      code = {2'b00, x, y};
    end else begin
      code = {1'b0, y, 1'b0, x};
    end
  end

endmodule

// File: rtl/pack_serializer.sv
// Packs an operand pair into an 8-bit code and shifts it out LSB first, each bit held BIT_CYCLES clocks.
// Define PACK_SER_PARITY_EN to append an even-parity bit after bit 7.
module pack_serializer
  import pack_ser_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [OPND_W-1:0] x,
  input  logic [OPND_W-1:0] y,
  output logic [CODE_W-1:0] code,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              done
);

  localparam logic [3:0] LAST_CYC = 4'(BIT_CYCLES - 1);

  state_t              state;
  logic [2:0]          bit_idx;
  logic [2:0]          next_idx;
  logic [3:0]          cyc_cnt;
  logic [CODE_W-1:0]   pack_val;

  pack_code u_pack_code (
    .mode (mode),
    .x    (x),
    .y    (y),
    .code (pack_val)
  );

  assign next_idx = bit_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      code        <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      in_ready    <= 1'b1;
      bit_idx     <= '0;
      cyc_cnt     <= '0;
    end else begin
      frame_start <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Drive bit 0 straight from the packer so it appears on the next cycle.
            code        <= pack_val;
            ser_out     <= pack_val[0];
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
            in_ready    <= 1'b0;
            bit_idx     <= '0;
            cyc_cnt     <= '0;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cyc_cnt == LAST_CYC) begin
            cyc_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef PACK_SER_PARITY_EN
              ser_out <= ^code;
              state   <= ST_PARITY;
`else
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
`endif
            end else begin
              bit_idx <= next_idx;
              ser_out <= code[next_idx];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 4'd1;
          end
        end
`ifdef PACK_SER_PARITY_EN
        ST_PARITY: begin
          if (cyc_cnt == LAST_CYC) begin
            cyc_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cyc_cnt <= cyc_cnt + 4'd1;
          end
        end
`endif
        ST_DONE: begin
          in_ready <= 1'b1;
          bit_idx  <= '0;
          state    <= ST_IDLE;
        end
        default: begin
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pack_serializer.md
PACK_SERIALIZER -- requirements
Module: pack_serializer

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 1, clocks each serial bit is held; legal range 1..16.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port mode  input  1  packing select: 0 = 8*x+y, 1 = x+16*y.
REQ-007 SHALL have port x  input  3  first operand, unsigned.
REQ-008 SHALL have port y  input  3  second operand, unsigned.
REQ-009 SHALL have port code  output  8  registered packed value of the last accepted pair.
REQ-010 SHALL have port ser_out  output  1  serial data, LSB first.
REQ-011 SHALL have port ser_valid  output  1  high while ser_out carries a frame bit.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse coincident with the first bit-0 cycle.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-014 SHALL accept a pair on a rising edge where in_valid && in_ready; mode, x and y are sampled only on that edge.
REQ-015 SHALL compute code as 8*x+y (mode 0, max 63) or x+16*y (mode 1, max 119), zero-extended to 8 bits, with no overflow possible.
REQ-016 SHALL implement the states IDLE, SHIFT, PARITY (macro only) and DONE.
REQ-017 IDLE: in_ready=1, ser_valid=0, ser_out=0; acceptance -> SHIFT, with code updated on the same edge.
REQ-018 SHIFT: in_ready=0, ser_valid=1, ser_out=code[bit_idx]; each bit is held exactly BIT_CYCLES clocks; bit_idx runs 0..7, then -> PARITY if the macro is defined, else -> DONE.
REQ-019 DONE: lasts exactly one cycle, done=1, ser_valid=0, in_ready=0; then -> IDLE.
REQ-020 Frame latency SHALL be: first bit on the cycle after acceptance; accept-to-accept spacing of 8*BIT_CYCLES+2 cycles (+BIT_CYCLES with parity) when in_valid is held high.
REQ-021 in_valid outside IDLE SHALL be ignored, with no capture, queuing or effect on the current frame.
REQ-022 code SHALL hold its value until the next acceptance.

Reset
REQ-023 With rst_n=0 at a rising edge, SHALL enter IDLE and set code=0, ser_out=0, ser_valid=0, frame_start=0, done=0, in_ready=1 and clear the bit and cycle counters.
REQ-024 Reset mid-frame SHALL abort the frame without a done pulse; the pair presented at the first post-reset IDLE edge is accepted normally.
REQ-025 in_valid while rst_n=0 SHALL NOT be accepted.

Configuration
REQ-026 Macro PACK_SER_PARITY_EN defined: after bit 7 SHALL enter PARITY for BIT_CYCLES clocks with ser_valid=1 and ser_out = XOR of code[7:0] (even parity), then -> DONE.
REQ-027 Macro PACK_SER_PARITY_EN undefined: the PARITY state and logic SHALL be absent, and the frame is 8 bits.

Structure
REQ-028 Package pack_ser_pkg SHALL hold the state encoding, CODE_W=8, OPND_W=3, and the MODE_XY8=0 and MODE_YX16=1 constants.
REQ-029 The packing arithmetic SHALL be a combinational sub-module pack_code (mode, x, y -> 8-bit value), instantiated once.

Verification
REQ-030 Bench SHALL apply mode=0, x=5, y=3 -> code=0x2B; ser_out over 8 bits = 1,1,0,1,0,1,0,0; frame_start on the first bit; done 1 cycle after bit 7.
REQ-031 Bench SHALL apply mode=1, x=7, y=7 with BIT_CYCLES=3 -> code=0x77; each bit is stable for 3 clocks; ser_valid is high for 24 cycles.
REQ-032 Bench SHALL hold in_valid high and step pairs (0,0), (7,7), (3,4) in mode 0 -> accepts 10 cycles apart (BIT_CYCLES=1); codes 0x00, 0x3F, 0x1C; no pair is captured mid-frame.
REQ-033 Bench SHALL assert rst_n=0 during bit 4 of frame x=2, y=1, mode 1 -> the next edge gives all outputs at reset values and in_ready=1, with no done pulse.
REQ-034 Bench SHALL define PACK_SER_PARITY_EN and apply mode=0, x=1, y=0 -> code=0x08; the 9th bit is 1; accept-to-accept spacing is 11 cycles.
REQ-035 Bench SHALL apply mode=1, x=0, y=7 -> code=0x70; serial bits = 0,0,0,0,1,1,1,0.
